// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one RAM port: core priority, host starvation
// protection, bounded host lock bursts, and read-valid tagging per owner.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned MAX_WAIT   = 8,
  parameter int unsigned MAX_HOLD   = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] c_wdata,
  output logic                  c_gnt,
  output logic                  c_rvalid,
  input  logic                  h_req,
  input  logic                  h_we,
  input  logic [ADDR_WIDTH-1:0] h_addr,
  input  logic [DATA_WIDTH-1:0] h_wdata,
  input  logic                  h_lock,
  output logic                  h_gnt,
  output logic                  h_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    HOST_LOCK = 2'd1
  } state_e;

  state_e                state_q, state_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic [HW-1:0]         hold_q, hold_d, hold_inc;
  logic [RD_LATENCY-1:0] tag_v_q, tag_v_d;
  logic [RD_LATENCY-1:0] tag_h_q, tag_h_d;

  // Grants are gated by rstn so the port is quiet while reset is held.
  always_comb begin
    h_gnt = 1'b0;
    c_gnt = 1'b0;
    if (rstn) begin
      if (state_q == HOST_LOCK) begin
        h_gnt = h_req;
      end else begin
        h_gnt = h_req & (~c_req | (wait_q == WAIT_MAX));
        c_gnt = c_req & ~h_gnt;
      end
    end
  end

  always_comb begin
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_wr_en   = 1'b0;
    if (h_gnt) begin
      mem_addr    = h_addr;
      mem_wr_data = h_wdata;
      mem_wr_en   = h_we;
    end else if (c_gnt) begin
      mem_addr    = c_addr;
      mem_wr_data = c_wdata;
      mem_wr_en   = c_we;
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    hold_inc = hold_q + HW'(1);
    case (state_q)
      ARB: begin
        // With MAX_HOLD of one the entry beat already exhausts the burst.
        if (h_gnt && h_lock && (HOLD_MAX > HW'(1))) begin
          state_d = HOST_LOCK;
          hold_d  = HW'(1);
        end
      end
      HOST_LOCK: begin
        if (!h_req) begin
          state_d = ARB;
          hold_d  = '0;
        end else begin
          hold_d = hold_inc;
          if (!h_lock || (hold_inc == HOLD_MAX)) begin
            state_d = ARB;
            hold_d  = '0;
          end
        end
      end
      default: begin
        state_d = ARB;
        hold_d  = '0;
      end
    endcase

    if (h_req && !h_gnt) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WW'(1);
    end else begin
      wait_d = '0;
    end

    tag_v_d    = '0;
    tag_h_d    = '0;
    tag_v_d[0] = (h_gnt | c_gnt) & ~mem_wr_en;
    tag_h_d[0] = h_gnt;
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_h_d[i] = tag_h_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ARB;
      wait_q  <= '0;
      hold_q  <= '0;
      tag_v_q <= '0;
      tag_h_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      hold_q  <= hold_d;
      tag_v_q <= tag_v_d;
      tag_h_q <= tag_h_d;
    end
  end

  assign c_rvalid = tag_v_q[RD_LATENCY-1] & ~tag_h_q[RD_LATENCY-1];
  assign h_rvalid = tag_v_q[RD_LATENCY-1] &  tag_h_q[RD_LATENCY-1];
  assign rdata    = mem_rd_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic,
// checked every cycle against a cycle-count based reference model.
module tb_mem_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 64;
  localparam int L  = 2;
  localparam int MW = 8;
  localparam int MH = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          c_req, c_we, h_req, h_we, h_lock;
  logic [AW-1:0] c_addr, h_addr;
  logic [DW-1:0] c_wdata, h_wdata;
  logic          c_gnt, c_rvalid, h_gnt, h_rvalid, mem_wr_en;
  logic [DW-1:0] rdata, mem_wr_data, mem_rd_data;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(L), .MAX_WAIT(MW), .MAX_HOLD(MH)
  ) dut (
    .clk(clk), .rstn(rstn),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_lock(h_lock), .h_gnt(h_gnt), .h_rvalid(h_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  function automatic logic [DW-1:0] init_word(logic [AW-1:0] a);
    return {20'hC0DE5, a, 20'h0BEEF, a};
  endfunction

  // RAM behind the port: unwritten words read as init_word(addr).
  logic [DW-1:0] ram [4096];
  bit            ram_wr [4096];
  logic [DW-1:0] rd_pipe [L];

  always @(posedge clk) begin
    if (mem_wr_en) begin
      ram[mem_addr]    <= mem_wr_data;
      ram_wr[mem_addr] <= 1'b1;
    end
    rd_pipe[0] <= ram_wr[mem_addr] ? ram[mem_addr] : init_word(mem_addr);
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rd_data = rd_pipe[L-1];

  // Reference model state
  logic [DW-1:0] ref_mem [4096];
  bit            ref_wr [4096];
  bit            m_locked;
  int            m_wait, m_hold;
  int            exp_own [int];
  logic [DW-1:0] exp_dat [int];
  int            cyc;
  bit            last_c, last_h;
  int            obs_h, obs_c;
  int            n_cmp, n_err;
  logic [AW-1:0] c_seq, h_seq;

  function automatic logic [DW-1:0] ref_rd(logic [AW-1:0] a);
    return ref_wr[a] ? ref_mem[a] : init_word(a);
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_update(input bit eh, input bit ec);
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (eh || ec) begin
      we = eh ? h_we : c_we;
      a  = eh ? h_addr : c_addr;
      d  = eh ? h_wdata : c_wdata;
      if (we) begin
        ref_mem[a] = d;
        ref_wr[a]  = 1'b1;
      end else begin
        exp_own[cyc + L] = eh ? 2 : 1;
        exp_dat[cyc + L] = ref_rd(a);
      end
    end
    if (!m_locked) begin
      if (eh && h_lock && MH > 1) begin
        m_locked = 1'b1;
        m_hold   = 1;
      end
    end else if (!h_req) begin
      m_locked = 1'b0;
    end else begin
      m_hold++;
      if (!h_lock || m_hold == MH) m_locked = 1'b0;
    end
    if (h_req && !eh) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
    else m_wait = 0;
  endtask

  // One clock cycle: predict, check at the falling edge, advance the model.
  task automatic cycle();
    bit            eh, ec;
    int            own;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    bit            ew;
    eh = rstn && h_req && (m_locked || !c_req || m_wait >= MW);
    ec = rstn && c_req && !m_locked && !eh;
    ea = eh ? h_addr : (ec ? c_addr : '0);
    ed = eh ? h_wdata : (ec ? c_wdata : '0);
    ew = eh ? h_we : (ec ? c_we : 1'b0);
    @(negedge clk);
    chk("c_gnt", c_gnt, ec);
    chk("h_gnt", h_gnt, eh);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wr_data", mem_wr_data, ed);
    chk("mem_wr_en", mem_wr_en, ew);
    own = exp_own.exists(cyc) ? exp_own[cyc] : 0;
    chk("c_rvalid", c_rvalid, own == 1);
    chk("h_rvalid", h_rvalid, own == 2);
    if (own != 0) chk("rdata", rdata, exp_dat[cyc]);
    if (h_gnt) obs_h++;
    if (c_gnt) obs_c++;
    @(posedge clk);
    #1;
    if (rstn) model_update(eh, ec);
    last_c = ec;
    last_h = eh;
    cyc++;
  endtask

  // Requesters hold their request until granted, then draw a new one.
  task automatic run(input int n, input int cp, input int cwp, input int hp,
                     input int hwp, input int lp, input bit seq);
    repeat (n) begin
      if (!c_req || last_c) begin
        c_req   = $urandom_range(99) < cp;
        c_we    = $urandom_range(99) < cwp;
        c_addr  = seq ? c_seq : AW'($urandom_range(63));
        c_wdata = {$urandom, $urandom};
        if (seq && c_req) c_seq++;
      end
      if (!h_req || last_h) begin
        h_req   = $urandom_range(99) < hp;
        h_we    = $urandom_range(99) < hwp;
        h_lock  = $urandom_range(99) < lp;
        h_addr  = seq ? h_seq : AW'($urandom_range(63));
        h_wdata = {$urandom, $urandom};
        if (seq && h_req) h_seq++;
      end
      cycle();
    end
  endtask

  task automatic do_reset(input int n);
    rstn     = 1'b0;
    m_locked = 1'b0;
    m_wait   = 0;
    m_hold   = 0;
    exp_own.delete();
    exp_dat.delete();
    repeat (n) cycle();
    rstn = 1'b1;
  endtask

  task automatic idle(input int n);
    c_req = 1'b0;
    h_req = 1'b0;
    h_lock = 1'b0;
    repeat (n) cycle();
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; obs_h = 0; obs_c = 0;
    last_c = 1'b0; last_h = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0; h_lock = 1'b0;
    c_seq = '0; h_seq = '0;
    m_locked = 1'b0; m_wait = 0; m_hold = 0;
    rstn = 1'b0;
    #1;
    // Reset: outputs quiet even with a request present
    c_req = 1'b1;
    do_reset(2);
    idle(2);

    // Core-only reads of 0x005..0x008
    c_seq = 12'h005;
    obs_c = 0;
    run(4, 100, 0, 0, 0, 0, 1'b1);
    idle(4);
    chk("core_only_gnts", 64'(obs_c), 64'd4);

    // Starvation: host gets one beat in every nine
    obs_h = 0;
    run(40, 100, 0, 100, 0, 0, 1'b0);
    chk("starve_host_gnts", 64'(obs_h), 64'd4);
    idle(3);

    // Host lock burst of writes at 0x100.., core joins after the first beat
    h_seq = 12'h100;
    obs_h = 0;
    run(1, 0, 0, 100, 100, 100, 1'b1);
    run(15, 100, 0, 100, 100, 100, 1'b1);
    chk("lock_host_gnts", 64'(obs_h), 64'd16);
    obs_c = 0;
    run(1, 100, 0, 100, 100, 100, 1'b1);
    chk("lock_core_after", 64'(obs_c), 64'd1);
    idle(3);
    c_seq = 12'h100;
    run(16, 100, 0, 0, 0, 0, 1'b1);
    idle(4);

    // Early lock release on beat 3
    h_req = 1'b1; h_we = 1'b1; h_lock = 1'b1; h_addr = 12'h200; h_wdata = 64'h1111;
    cycle();
    c_req = 1'b1; c_we = 1'b0; c_addr = 12'h200;
    h_addr = 12'h201; h_wdata = 64'h2222;
    cycle();
    h_addr = 12'h202; h_wdata = 64'h3333; h_lock = 1'b0;
    cycle();
    h_addr = 12'h203; h_wdata = 64'h4444;
    obs_c = 0;
    cycle();
    chk("early_release_core", 64'(obs_c), 64'd1);
    idle(4);

    // Mixed tags: core read, host read, core write
    c_req = 1'b1; c_we = 1'b0; c_addr = 12'h005;
    cycle();
    c_req = 1'b0; h_req = 1'b1; h_we = 1'b0; h_addr = 12'h101;
    cycle();
    h_req = 1'b0; c_req = 1'b1; c_we = 1'b1; c_addr = 12'h020; c_wdata = 64'hDEAD_BEEF_0BAD_F00D;
    cycle();
    idle(4);

    // Random traffic
    run(600, 60, 30, 40, 30, 60, 1'b0);
    idle(4);

    // Reset while a read's rvalid is due: it must vanish and never return
    c_req = 1'b1; c_we = 1'b0; c_addr = 12'h020;
    cycle();
    c_req = 1'b0;
    cycle();
    do_reset(2);
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
